// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port 1024x32 data RAM between the CPU MEM
// stage (port 0, fixed priority) and a debug/DMA port (port 1). A saturating
// wait counter forces a single one-access DMA grant after MAX_WAIT
// consecutive denied cycles. Read data returns one cycle after the grant and
// is steered to the port recorded in a one-deep owner register.
// Optional feature macro: DMEM_ARB_PERF_EN adds stall / forced-grant counters.

module dmem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [31:0]       dma_addr,
  input  logic [31:0]       dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [31:0]       dma_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_cpu_stall_cnt,
  output logic [31:0]       perf_dma_force_cnt
`endif
);

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } state_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);
  localparam logic [7:0] WAIT_SAT_C = 8'hFF;

  state_t              state_r;
  logic [7:0]          wait_cnt_r;
  logic [7:0]          wait_cnt_next_s;
  logic                owner_valid_r;
  logic                owner_port_r;
  logic [ADDR_W-1:0]   ram_addr_r;

  logic                cpu_gnt_s;
  logic                dma_gnt_s;
  logic                ram_we_s;
  logic [ADDR_W-1:0]   ram_addr_s;
  logic [31:0]         ram_din_s;
  logic                rd_grant_s;
  logic [ADDR_W-1:0]   cpu_word_s;
  logic [ADDR_W-1:0]   dma_word_s;
  logic                unused_addr_s;

  // Only the word-address field of each byte address reaches the RAM.
  assign cpu_word_s    = cpu_addr[ADDR_W+1:2];
  assign dma_word_s    = dma_addr[ADDR_W+1:2];
  assign unused_addr_s = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                           dma_addr[31:ADDR_W+2], dma_addr[1:0]};

  // Grant selection: forced DMA slot first, then CPU priority, then DMA.
  always_comb begin
    cpu_gnt_s = 1'b0;
    dma_gnt_s = 1'b0;
    if (!rst) begin
      cpu_gnt_s = 1'b0;
      dma_gnt_s = 1'b0;
    end else if ((state_r == ST_FORCE) && dma_req) begin
      dma_gnt_s = 1'b1;
    end else if (cpu_req) begin
      cpu_gnt_s = 1'b1;
    end else if (dma_req) begin
      dma_gnt_s = 1'b1;
    end else begin
      cpu_gnt_s = 1'b0;
      dma_gnt_s = 1'b0;
    end
  end

  // RAM port mux from the granted requester; address holds when idle.
  always_comb begin
    ram_we_s   = 1'b0;
    ram_addr_s = ram_addr_r;
    ram_din_s  = 32'd0;
    rd_grant_s = 1'b0;
    if (cpu_gnt_s) begin
      ram_we_s   = cpu_we & cpu_req;
      ram_addr_s = cpu_word_s;
      ram_din_s  = cpu_wdata;
      rd_grant_s = ~cpu_we;
    end else if (dma_gnt_s) begin
      ram_we_s   = dma_we & dma_req;
      ram_addr_s = dma_word_s;
      ram_din_s  = dma_wdata;
      rd_grant_s = ~dma_we;
    end else begin
      ram_we_s   = 1'b0;
      ram_addr_s = ram_addr_r;
      ram_din_s  = 32'd0;
      rd_grant_s = 1'b0;
    end
  end

  // Next wait count: clear on grant or no request, otherwise saturating +1.
  always_comb begin
    wait_cnt_next_s = wait_cnt_r;
    if (!dma_req || dma_gnt_s) begin
      wait_cnt_next_s = 8'd0;
    end else if (wait_cnt_r != WAIT_SAT_C) begin
      wait_cnt_next_s = wait_cnt_r + 8'd1;
    end else begin
      wait_cnt_next_s = wait_cnt_r;
    end
  end

  // Arbitration FSM and wait counter; FORCE lasts for one DMA access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_NORMAL;
      wait_cnt_r <= 8'd0;
    end else begin
      wait_cnt_r <= wait_cnt_next_s;
      case (state_r)
        ST_NORMAL: begin
          if (wait_cnt_next_s >= MAX_WAIT_C) begin
            state_r <= ST_FORCE;
          end else begin
            state_r <= ST_NORMAL;
          end
        end
        ST_FORCE: begin
          if (dma_gnt_s || !dma_req) begin
            state_r <= ST_NORMAL;
          end else begin
            state_r <= ST_FORCE;
          end
        end
        default: state_r <= ST_NORMAL;
      endcase
    end
  end

  // Read-return owner and last driven RAM address; updated every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_valid_r <= 1'b0;
      owner_port_r  <= 1'b0;
      ram_addr_r    <= '0;
    end else begin
      owner_valid_r <= rd_grant_s;
      owner_port_r  <= dma_gnt_s;
      ram_addr_r    <= ram_addr_s;
    end
  end

  assign cpu_stall  = rst & cpu_req & ~cpu_gnt_s;
  assign dma_gnt    = dma_gnt_s;
  assign ram_we     = ram_we_s;
  assign ram_addr   = ram_addr_s;
  assign ram_din    = ram_din_s;
  assign cpu_rvalid = owner_valid_r & ~owner_port_r;
  assign dma_rvalid = owner_valid_r &  owner_port_r;
  assign cpu_rdata  = cpu_rvalid ? ram_dout : 32'd0;
  assign dma_rdata  = dma_rvalid ? ram_dout : 32'd0;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_stall_r;
  logic [31:0] perf_force_r;

  // Performance counters: stalled CPU cycles and forced DMA grants (wrap).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_r <= 32'd0;
      perf_force_r <= 32'd0;
    end else begin
      if (cpu_stall) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end
      if ((state_r == ST_FORCE) && dma_gnt_s) begin
        perf_force_r <= perf_force_r + 32'd1;
      end
    end
  end

  assign perf_cpu_stall_cnt = perf_stall_r;
  assign perf_dma_force_cnt = perf_force_r;
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data RAM (word-addressed, 1024 x 32, one-cycle synchronous read) between two requesters.
- Requester 0 is the pipeline CPU MEM stage. Requester 1 is a debug/DMA port used for program load and memory inspection.
- Fixed CPU priority with a starvation guard for the DMA port. Produces a stall to the CPU and per-port read-data valid.

Parameters:
- ADDR_W, 10, RAM word-address width; byte address bits [ADDR_W+1:2] are used.
- MAX_WAIT, 8, consecutive cycles DMA may be denied before a forced DMA grant; legal range 1..255.

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU MEM-stage access request
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  32  CPU byte address
- cpu_wdata  in  32  CPU write data
- cpu_stall  out  1  cpu_req & ~cpu_gnt; freezes the pipeline
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  32  CPU read data
- dma_req  in  1  DMA access request
- dma_we  in  1  DMA write / read
- dma_addr  in  32  DMA byte address
- dma_wdata  in  32  DMA write data
- dma_gnt  out  1  DMA request accepted this cycle
- dma_rvalid  out  1  DMA read data valid
- dma_rdata  out  32  DMA read data
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM word address
- ram_din  out  32  RAM write data
- ram_dout  in  32  RAM read data, one cycle after address

Behaviour:
- Grant logic is combinational from the requests and registered state. At most one grant per cycle.
- FSM states:
  - NORMAL: CPU wins whenever cpu_req=1. DMA is granted only when cpu_req=0.
  - FORCE: DMA wins if dma_req=1, and cpu_stall=1 if cpu_req=1. If dma_req=0, behave as NORMAL.
- Wait counter (8-bit):
  - Increments when dma_req=1 and dma_gnt=0.
  - Clears on any dma_gnt or when dma_req=0.
  - Saturates; never wraps.
- Transitions:
  - NORMAL -> FORCE when the counter reaches MAX_WAIT at a clock edge.
  - FORCE -> NORMAL after exactly one DMA grant, or when dma_req drops.
  - A forced grant is therefore one access wide.
- RAM mux:
  - ram_addr/ram_din/ram_we come from the granted port.
  - ram_we = granted_we & granted_req.
  - With no grant: ram_we=0 and ram_addr holds its last driven value (registered copy).
- Read return:
  - A one-deep owner register records {valid, port} for a granted read.
  - Next cycle, the owner's rvalid=1 and its rdata=ram_dout. The other port's rdata reads 0.
  - Writes never produce rvalid.
- Back-to-back reads from different ports in consecutive cycles are legal. The owner register updates every cycle, so returns are in order with no bubble.
- Simultaneous requests in the same cycle as the counter threshold: the transition takes effect the next cycle, and the CPU still wins the current one.
- Reset (asserted, any time, including mid-access):
  - State=NORMAL, counter=0, owner valid=0.
  - cpu_rvalid=0, dma_rvalid=0, ram_we=0, ram_addr=0.
  - A pending read return is dropped.
  - Grants are forced to 0 and cpu_stall=0 while rst=0.
- Address bits outside [ADDR_W+1:2] are ignored; no bounds error.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_cpu_stall_cnt[31:0] and perf_dma_force_cnt[31:0].
  - They count cycles with cpu_stall=1, and FORCE-state DMA grants.
  - Both wrap at 2^32 and clear on reset.
- Undefined: these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, then CPU write addr 0x0000_0010 data 0xDEADBEEF, CPU read 0x10 -> ram_addr=4, ram_we=1 on write; next cycle after read, cpu_rvalid=1, cpu_rdata=0xDEADBEEF, cpu_stall=0 throughout.
- DMA write 0x20=0x12345678 with cpu_req=0 -> dma_gnt=1 same cycle; CPU read 0x20 returns 0x12345678.
- cpu_req held 1 continuously, dma_req=1 (MAX_WAIT=8) -> dma_gnt=0 for 8 cycles, dma_gnt=1 and cpu_stall=1 on cycle 9, CPU regains grant on cycle 10, counter 0.
- Alternating CPU read 0x4 / DMA read 0x8 on consecutive idle-CPU gaps -> rvalid toggles to correct port each cycle, data matches, no cross-delivery.
- Assert rst low one cycle after granted CPU read -> cpu_rvalid stays 0, state NORMAL, ram_we=0 immediately (asynchronous).
- With DMEM_ARB_PERF_EN, scenario 3 -> perf_cpu_stall_cnt=1, perf_dma_force_cnt=1.
